// File: rtl/posit_pkg.sv
// Shared posit definitions: supported formats, their bit widths and the
// operation codes understood by the posit arithmetic units.
package posit_pkg;

  typedef enum logic [1:0] {
    POSIT32 = 2'd0,
    POSIT16 = 2'd1,
    POSIT8  = 2'd2,
    POSIT64 = 2'd3
  } posit_format_e;

  typedef enum logic [2:0] {
    FMADD  = 3'd0,
    FNMSUB = 3'd1,
    ADD    = 3'd2,
    MUL    = 3'd3,
    DIV    = 3'd4,
    SQRT   = 3'd5
  } operation_e;

  function automatic int unsigned posit_width(input posit_format_e fmt);
    case (fmt)
      POSIT16: return 16;
      POSIT8:  return 8;
      POSIT64: return 64;
      default: return 32;
    endcase
  endfunction

endpackage

// File: rtl/posit_dot_seq.sv
// Dot-product sequencer: streams element pairs into an external posit FMA
// unit, chaining each result back as the next accumulator operand.
module posit_dot_seq #(
  parameter posit_pkg::posit_format_e pFormat = posit_pkg::posit_format_e'(0),
  parameter int unsigned MAX_LEN = 256,
  localparam int unsigned WIDTH = posit_pkg::posit_width(pFormat),
  localparam int unsigned LW    = $clog2(MAX_LEN + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic                        start_valid_i,
  output logic                        start_ready_o,
  input  logic [LW-1:0]               len_i,
  input  logic [WIDTH-1:0]            acc_init_i,
  input  logic                        elem_valid_i,
  output logic                        elem_ready_o,
  input  logic [WIDTH-1:0]            elem_a_i,
  input  logic [WIDTH-1:0]            elem_b_i,
  output logic [2:0][WIDTH-1:0]       fma_operands_o,
  output posit_pkg::operation_e       fma_op_o,
  output logic                        fma_op_mod_o,
  output logic                        fma_tag_o,
  output logic                        fma_in_valid_o,
  input  logic                        fma_in_ready_i,
  output logic                        fma_flush_o,
  input  logic [WIDTH-1:0]            fma_result_i,
  input  logic                        fma_tag_i,
  input  logic                        fma_out_valid_i,
  output logic                        fma_out_ready_o,
  output logic                        res_valid_o,
  input  logic                        res_ready_i,
  output logic [WIDTH-1:0]            res_o,
  output logic                        busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic             tag_q, tag_d;
  logic             outst_q, outst_d;

  logic start_hs, issue_hs, capture, last_elem;

  assign start_hs  = start_valid_i & start_ready_o;
  assign issue_hs  = fma_in_valid_o & fma_in_ready_i;
  // A combinational unit answers in the issue cycle, before outst_q is set.
  assign capture   = fma_out_valid_i & fma_out_ready_o & (outst_q | issue_hs) &
                     (fma_tag_i == tag_q);
  assign last_elem = (cnt_q == LW'(1));

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      tag_q   <= 1'b0;
      outst_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      outst_q <= outst_d;
    end
  end

  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    outst_d = outst_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_hs) begin
          acc_d   = acc_init_i;
          cnt_d   = len_i;
          tag_d   = 1'b0;
          outst_d = 1'b0;
          state_d = (len_i == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue_hs) outst_d = 1'b1;
        if (capture)       state_d = last_elem ? S_DONE : S_ISSUE;
        else if (issue_hs) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (capture) state_d = last_elem ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        if (res_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (capture) begin
      acc_d   = fma_result_i;
      tag_d   = ~tag_q;
      cnt_d   = cnt_q - LW'(1);
      outst_d = 1'b0;
    end
    if (flush_i) begin
      state_d = S_IDLE;
      outst_d = 1'b0;
    end
  end

  always_comb begin
    start_ready_o   = 1'b0;
    elem_ready_o    = 1'b0;
    fma_in_valid_o  = 1'b0;
    fma_out_ready_o = 1'b0;
    res_valid_o     = 1'b0;
    res_o           = '0;
    unique case (state_q)
      S_IDLE:  start_ready_o = ~flush_i;
      S_ISSUE: begin
        fma_in_valid_o  = elem_valid_i;
        elem_ready_o    = fma_in_ready_i;
        fma_out_ready_o = 1'b1;
      end
      S_WAIT:  fma_out_ready_o = 1'b1;
      S_DONE: begin
        res_valid_o = 1'b1;
        res_o       = acc_q;
      end
      default: ;
    endcase
  end

  assign fma_operands_o = {acc_q, elem_b_i, elem_a_i};
  assign fma_op_o       = posit_pkg::FMADD;
  assign fma_op_mod_o   = 1'b0;
  assign fma_tag_o      = tag_q;
  assign fma_flush_o    = flush_i & rst_ni;
  assign busy_o         = (state_q != S_IDLE);

endmodule
